// File: rtl/cla_slice_addsub.sv
// Multi-cycle adder/subtractor that resolves one 3-bit carry-lookahead slice per clock,
// starting at the LSB slice, with valid/ready handshakes on both the operand and result sides.
module cla_slice_addsub #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int NSLICE = WIDTH / 3;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             carry_q, carry_out_q, overflow_q;

  logic [31:0] base;
  logic [2:0]  as, bs, g, p, sum_s;
  logic        c0, c1, cout, last_slice, accept;

  // Handshake: a transfer happens on any rising edge where valid and ready are both high;
  // ready never depends on valid, and a held valid is not consumed until ready is seen.
  assign in_ready   = !rst && (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_slice = (cnt == CW'(NSLICE - 1));

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign state_dbg = state;

  // Slice datapath for the slice selected by the counter.
  assign base  = {{(32-CW){1'b0}}, cnt} * 32'd3;
  assign as    = a_q[base +: 3];
  assign bs    = b_q[base +: 3];
  assign g     = as & bs;
  assign p     = as ^ bs;
  assign c0    = g[0] | (p[0] & carry_q);
  assign c1    = g[1] | (p[1] & c0);
  assign cout  = g[2] | (p[2] & c1);
  assign sum_s = p ^ {c1, c0, carry_q};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= a;
            b_q      <= b ^ {WIDTH{sub}};
            carry_q  <= sub;
            cnt      <= '0;
            result_q <= '0;
          end
        end
        BUSY: begin
          result_q[base +: 3] <= sum_s;
          carry_q             <= cout;
          cnt                 <= cnt + CW'(1);
          if (last_slice) begin
            carry_out_q <= cout;
            // c1 of the top slice is the carry into the MSB.
            overflow_q  <= c1 ^ cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_slice_addsub.sv
// Directed bench for cla_slice_addsub at WIDTH=12: hand-computed sums/differences,
// latency, DONE back-pressure and mid-operation reset.
module tb_cla_slice_addsub;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;

  cla_slice_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; caller has checked in_ready.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s);
    a        = aa;
    b        = bb;
    sub      = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = $urandom_range(0, 4095);
    b        = $urandom_range(0, 4095);
    sub      = $urandom_range(0, 1);
  endtask

  // Waits for out_valid with a cycle bound; returns edges counted since acceptance.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic s, input logic [W-1:0] er, input logic ec, input logic ev);
    int lat;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    send(aa, bb, s);
    wait_done(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_carry"}, 32'(carry_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(ev));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] held;
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    tick();

    run_op("add_7ff_1", 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1);
    run_op("sub_5_7",   12'h005, 12'h007, 1'b1, 12'hFFE, 1'b0, 1'b0);
    run_op("sub_800_1", 12'h800, 12'h001, 1'b1, 12'h7FF, 1'b1, 1'b1);
    run_op("add_fff_1", 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0);
    run_op("add_abc",   12'hABC, 12'h123, 1'b0, 12'hBDF, 1'b0, 1'b0);
    run_op("add_800",   12'h800, 12'h800, 1'b0, 12'h000, 1'b1, 1'b1);
    run_op("sub_0_0",   12'h000, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0);
    run_op("sub_7ff_m1",12'h7FF, 12'hFFF, 1'b1, 12'h800, 1'b0, 1'b1);

    // Back-pressure in DONE with new operands offered.
    send(12'h100, 12'h023, 1'b0);
    wait_done(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    held = 12'h123;
    for (int i = 0; i < 5; i++) begin
      a = 12'h555; b = 12'h0AA; sub = 1'b1; in_valid = 1'b1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'(held));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (6) tick();
    chk("bp_no_ghost_op", 32'(out_valid), 32'd0);

    // Reset during the 2nd BUSY cycle.
    send(12'hFFF, 12'hFFF, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", 32'(in_ready), 32'd0);
    tick();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    repeat (5) tick();
    chk("abort_no_result", 32'(out_valid), 32'd0);
    run_op("fresh_123_456", 12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
